// File: rtl/micro_sequencer_if.sv
// Sequencer bus: instruction fetch handshake plus the program-counter
// command group (pi / pl / ms / extend).
// master = micro_sequencer side, slave = memory / program-counter side.
interface micro_sequencer_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        fetch_req;
  logic        pi;
  logic        pl;
  logic        ms;
  logic [7:0]  extend;

  modport master (
    input  instr,
    input  instr_valid,
    output fetch_req,
    output pi,
    output pl,
    output ms,
    output extend
  );

  modport slave (
    output instr,
    output instr_valid,
    input  fetch_req,
    input  pi,
    input  pl,
    input  ms,
    input  extend
  );
endinterface

// File: rtl/micro_sequencer.sv
// micro_sequencer: instruction-level control sequencer.
// FETCH -> DECODE -> EXEC -> PCUPD -> FETCH, HALT terminal.
// All strobes are registered from the state they belong to, so each strobe
// becomes visible in the cycle after that state (reg_we during PCUPD, the PC
// command in the following FETCH cycle). Exactly one PC command per
// instruction.
// Optional feature: define MSEQ_ILLEGAL_TRAP_EN to load TRAP_VEC into the PC
// on an illegal opcode; otherwise an illegal opcode executes as NOP.
module micro_sequencer (
  input  logic               i_clk,
  input  logic               i_rstn,
  micro_sequencer_if.master  bus,
  input  logic               i_zero,
  input  logic               i_neg,
  output logic [15:0]        o_ir,
  output logic [3:0]         o_alu_op,
  output logic               o_reg_we,
  output logic               o_illegal,
  output logic               o_halt,
  output logic [2:0]         o_state
);

`ifdef MSEQ_ILLEGAL_TRAP_EN
  localparam logic [7:0] TRAP_VEC = 8'hF0;
`endif

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_BZ   = 4'h4;
  localparam logic [3:0] OP_BN   = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_PCUPD  = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Opcodes 6..E are not part of the instruction set.
  function automatic logic is_illegal_op(input logic [3:0] op);
    logic ill;
    case (op)
      OP_NOP, OP_ALU, OP_LDI, OP_JMP, OP_BZ, OP_BN, OP_HALT: ill = 1'b0;
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  logic [15:0] ir_r;
  logic [3:0]  alu_op_r;
  logic        reg_we_r;
  logic        zero_r;
  logic        neg_r;
  logic        illegal_r;
  logic        halt_r;
  logic        fetch_req_r;
  logic        pi_r;
  logic        pl_r;
  logic        ms_r;
  logic [7:0]  extend_r;

  logic [3:0]  opcode_s;
  logic [7:0]  imm_s;
  logic        cmd_pi_s;
  logic        cmd_pl_s;
  logic        cmd_ms_s;
  logic [7:0]  cmd_ext_s;

  assign opcode_s = ir_r[15:12];
  assign imm_s    = ir_r[7:0];

  // Next-state logic: fetch waits on valid, HALT opcode diverts from DECODE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (bus.instr_valid) begin
          state_next_s = ST_DECODE;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (opcode_s == OP_HALT) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_EXEC;
        end
      end
      ST_EXEC:  state_next_s = ST_PCUPD;
      ST_PCUPD: state_next_s = ST_FETCH;
      ST_HALT:  state_next_s = ST_HALT;
      default:  state_next_s = ST_FETCH;
    endcase
  end

  // PC command selection, only meaningful while in PCUPD.
  always_comb begin
    cmd_pi_s  = 1'b0;
    cmd_pl_s  = 1'b0;
    cmd_ms_s  = 1'b0;
    cmd_ext_s = 8'h00;
    if (state_r == ST_PCUPD) begin
      case (opcode_s)
        OP_NOP, OP_ALU, OP_LDI: cmd_pi_s = 1'b1;
        OP_JMP: begin
          cmd_pl_s  = 1'b1;
          cmd_ext_s = imm_s;
        end
        OP_BZ: begin
          if (zero_r) begin
            cmd_ms_s  = 1'b1;
            cmd_ext_s = imm_s;
          end else begin
            cmd_pi_s  = 1'b1;
          end
        end
        OP_BN: begin
          if (neg_r) begin
            cmd_ms_s  = 1'b1;
            cmd_ext_s = imm_s;
          end else begin
            cmd_pi_s  = 1'b1;
          end
        end
        default: begin
`ifdef MSEQ_ILLEGAL_TRAP_EN
          cmd_pl_s  = 1'b1;
          cmd_ext_s = TRAP_VEC;
`else
          cmd_pi_s  = 1'b1;
`endif
        end
      endcase
    end else begin
      cmd_pi_s  = 1'b0;
      cmd_pl_s  = 1'b0;
      cmd_ms_s  = 1'b0;
      cmd_ext_s = 8'h00;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered outputs; reset clears every pending strobe of an aborted instruction.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      ir_r        <= 16'h0000;
      alu_op_r    <= 4'h0;
      reg_we_r    <= 1'b0;
      zero_r      <= 1'b0;
      neg_r       <= 1'b0;
      illegal_r   <= 1'b0;
      halt_r      <= 1'b0;
      fetch_req_r <= 1'b1;
      pi_r        <= 1'b0;
      pl_r        <= 1'b0;
      ms_r        <= 1'b0;
      extend_r    <= 8'h00;
    end else begin
      fetch_req_r <= (state_next_s == ST_FETCH);
      halt_r      <= (state_next_s == ST_HALT);
      if ((state_r == ST_FETCH) && bus.instr_valid) begin
        ir_r <= bus.instr;
      end
      if (state_r == ST_DECODE) begin
        alu_op_r  <= (opcode_s == OP_ALU) ? ir_r[11:8] : 4'h0;
        illegal_r <= illegal_r | is_illegal_op(opcode_s);
      end
      if (state_r == ST_EXEC) begin
        zero_r <= i_zero;
        neg_r  <= i_neg;
      end
      reg_we_r <= (state_r == ST_EXEC) &&
                  ((opcode_s == OP_ALU) || (opcode_s == OP_LDI));
      pi_r     <= cmd_pi_s;
      pl_r     <= cmd_pl_s;
      ms_r     <= cmd_ms_s;
      extend_r <= cmd_ext_s;
    end
  end

  assign bus.fetch_req = fetch_req_r & i_rstn;
  assign bus.pi        = pi_r;
  assign bus.pl        = pl_r;
  assign bus.ms        = ms_r;
  assign bus.extend    = extend_r;
  assign o_ir          = ir_r;
  assign o_alu_op      = alu_op_r;
  assign o_reg_we      = reg_we_r;
  assign o_illegal     = illegal_r;
  assign o_halt        = halt_r;
  assign o_state       = state_r;

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Instruction-level control sequencer for the microprogrammed CPU. Fetches a 16-bit instruction at the address held by the program counter, decodes it, drives ALU and register-file strobes, then issues exactly one program-counter command per instruction: increment (pi), absolute load (pl), or relative add (ms). It is the command source for the program counter's pi/pl/ms/extend inputs, and the only block that drives them.

## Interface
- TRAP_VEC, 8'hF0, absolute PC target loaded on an illegal opcode when trapping is compiled in
- i_clk  input  1  system clock, all logic on rising edge
- i_rstn  input  1  reset, synchronous, active-low
- i_instr  input  16  instruction word from instruction memory
- i_instr_valid  input  1  i_instr valid this cycle
- i_zero  input  1  ALU zero flag
- i_neg  input  1  ALU negative flag
- o_fetch_req  output  1  instruction fetch request at current PC
- o_ir  output  16  instruction register
- o_alu_op  output  4  ALU operation select (o_ir[11:8] for ALU instr, else 0)
- o_reg_we  output  1  register-file write strobe, one-cycle pulse
- o_pi  output  1  PC increment command, one-cycle pulse
- o_pl  output  1  PC absolute load command, one-cycle pulse
- o_ms  output  1  PC relative add command, one-cycle pulse
- o_extend  output  8  PC load value / signed offset, valid with o_pl or o_ms
- o_illegal  output  1  sticky illegal-opcode flag
- o_halt  output  1  sequencer halted
- o_state  output  3  current FSM state, debug

## Operation
- Instruction format: [15:12] opcode, [11:8] function/reg field, [7:0] imm.
- Opcodes: 0 NOP; 1 ALU; 2 LDI; 3 JMP; 4 BZ; 5 BN; F HALT; 6–E illegal.
- States: FETCH(0) -> DECODE(1) -> EXEC(2) -> PCUPD(3) -> FETCH; HALT(4) terminal.
- FETCH: o_fetch_req=1; stay until i_instr_valid=1, then o_ir <= i_instr, go DECODE. No timeout.
- DECODE: o_alu_op set from o_ir; HALT opcode -> HALT state, no PC command issued.
- EXEC: o_reg_we=1 for one cycle for ALU and LDI only; i_zero/i_neg sampled here.
- PCUPD: exactly one of o_pi/o_pl/o_ms high for one cycle:
  - NOP, ALU, LDI, untaken BZ/BN: o_pi.
  - JMP: o_pl, o_extend=imm.
  - Taken BZ (zero=1) / BN (neg=1): o_ms, o_extend=imm (two's-complement offset; PC wraps mod 256 in the counter).
  - Illegal: see Configuration.
- o_pi, o_pl, o_ms never asserted together; all zero outside PCUPD.
- o_extend = 0 whenever o_pl and o_ms are both low.
- HALT: all strobes 0, o_fetch_req=0, o_halt=1; exit only via reset.

## Timing
- Reset (i_rstn low at clock edge): state=FETCH, o_ir=0, o_alu_op=0, all strobes 0, o_extend=0, o_illegal=0, o_halt=0. o_fetch_req is forced to 0 while i_rstn is low.
- First o_fetch_req=1 in the first cycle after i_rstn rises.
- Zero-wait instruction: 4 cycles, FETCH to PCUPD. Each wait cycle on i_instr_valid adds 1 cycle.
- o_reg_we is asserted exactly 1 cycle before the PC command.
- Reset mid-instruction aborts it: no PC command is issued, and any pending o_reg_we is suppressed.
- i_instr_valid outside FETCH is ignored.

## Configuration
- Macro MSEQ_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode sets o_illegal, and PCUPD issues o_pl with o_extend=TRAP_VEC.
- Undefined: an illegal opcode sets o_illegal, executes as NOP, and PCUPD issues o_pi.
- o_illegal stays high until reset in both builds.

## Test plan
- Reset, then NOP (16'h0000) with valid on first FETCH cycle -> o_pi pulse exactly 4 cycles after fetch_req rises; no reg_we.
- ALU 16'h1305, valid delayed 3 cycles -> o_alu_op=4'h3, o_reg_we pulse in EXEC, o_pi pulse 7 cycles after fetch_req rises.
- JMP 16'h3042 -> o_pl=1 with o_extend=8'h42 for one cycle; o_pi/o_ms stay 0.
- BZ 16'h40FE with i_zero=1 -> o_ms=1 with o_extend=8'hFE. Repeat with i_zero=0 -> o_pi only, o_extend=0.
- Opcode 16'h7000 -> o_illegal=1 and stays set. With MSEQ_ILLEGAL_TRAP_EN: o_pl with o_extend=8'hF0. Without it: o_pi.
- HALT 16'hF000 -> o_halt=1 and no further fetch_req; then assert i_rstn low mid-EXEC of the next program -> all outputs zero, no PC pulse emitted.
